// File: rtl/adder_checker_if.sv
// Stimulus, response and result bundle between the adder test harness and
// the response checker.
interface adder_checker_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 16
);

  // Stimulus and adder response
  logic          valid_i;
  logic [W-1:0]  a_i;
  logic [W-1:0]  b_i;
  logic [W-1:0]  sum_i;
  logic          is_odd_i;
  logic          clear_i;

  // Checker results
  logic [CW-1:0] check_cnt_o;
  logic [CW-1:0] err_cnt_o;
  logic [1:0]    status_o;
  logic [W-1:0]  err_a_o;
  logic [W-1:0]  err_b_o;
  logic [W-1:0]  err_sum_o;
  logic          mismatch_o;

  // Harness side: drives stimulus/response, observes results
  modport master (
    output valid_i, a_i, b_i, sum_i, is_odd_i, clear_i,
    input  check_cnt_o, err_cnt_o, status_o, err_a_o, err_b_o, err_sum_o,
           mismatch_o
  );

  // Checker side
  modport slave (
    input  valid_i, a_i, b_i, sum_i, is_odd_i, clear_i,
    output check_cnt_o, err_cnt_o, status_o, err_a_o, err_b_o, err_sum_o,
           mismatch_o
  );

endinterface

// File: rtl/adder_checker.sv
// Response checker for the adder datapath: computes the expected sum/odd at
// stimulus time, delays it LAT cycles to meet the adder result, compares,
// counts, captures the first failure and reports IDLE/PASS/FAIL.
module adder_checker #(
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 2,
  parameter int unsigned CW  = 16
) (
  input  logic           clk,
  input  logic           reset_n_i,
  adder_checker_if.slave bus
);

  // One delay-line stage: a stimulus and the result it should produce
  typedef struct packed {
    logic         valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_odd;
  } stage_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  stage_t        pipe_q [LAT];
  stage_t        pipe_d [LAT];

  state_t        state_q, state_d;
  logic [CW-1:0] check_cnt_q, check_cnt_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [W-1:0]  err_a_q, err_a_d;
  logic [W-1:0]  err_b_q, err_b_d;
  logic [W-1:0]  err_sum_q, err_sum_d;
  logic          mismatch_q, mismatch_d;

  logic [W-1:0]  exp_sum_c;
  logic          cmp_c;
  logic          fail_c;
  logic          pass_c;
  stage_t        head_c;

  // Expected sum with the carry-out dropped
  assign exp_sum_c = bus.a_i + bus.b_i;

  // Stage LAT is the entry whose adder result is on sum_i this cycle
  assign head_c = pipe_q[LAT-1];
  assign cmp_c  = head_c.valid & ~bus.clear_i;
  assign fail_c = cmp_c & ((bus.sum_i != head_c.exp_sum) |
                           (bus.is_odd_i != head_c.exp_odd));
  assign pass_c = cmp_c & ~fail_c;

  // Delay line: load expected values at the head, shift every cycle, flush on clear
  always_comb begin
    pipe_d[0].valid   = bus.valid_i;
    pipe_d[0].a       = bus.a_i;
    pipe_d[0].b       = bus.b_i;
    pipe_d[0].exp_sum = exp_sum_c;
    pipe_d[0].exp_odd = exp_sum_c[0];
    for (int i = 1; i < int'(LAT); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (bus.clear_i) begin
      for (int i = 0; i < int'(LAT); i++) begin
        pipe_d[i].valid = 1'b0;
      end
    end
  end

  // Status FSM next state plus counters, capture and mismatch pulse
  always_comb begin
    state_d     = state_q;
    check_cnt_d = check_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_a_d     = err_a_q;
    err_b_d     = err_b_q;
    err_sum_d   = err_sum_q;
    mismatch_d  = fail_c;

    if (bus.clear_i) begin
      state_d     = ST_IDLE;
      check_cnt_d = '0;
      err_cnt_d   = '0;
      err_a_d     = '0;
      err_b_d     = '0;
      err_sum_d   = '0;
      mismatch_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fail_c)      state_d = ST_FAIL;
          else if (pass_c) state_d = ST_PASS;
        end
        ST_PASS: begin
          if (fail_c) state_d = ST_FAIL;
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase

      if (cmp_c && (check_cnt_q != CNT_MAX)) begin
        check_cnt_d = check_cnt_q + CW'(1);
      end
      if (fail_c && (err_cnt_q != CNT_MAX)) begin
        err_cnt_d = err_cnt_q + CW'(1);
      end
      // Only the first failure since reset/clear is kept
      if (fail_c && (state_q != ST_FAIL)) begin
        err_a_d   = head_c.a;
        err_b_d   = head_c.b;
        err_sum_d = bus.sum_i;
      end
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < int'(LAT); i++) begin
        pipe_q[i] <= '0;
      end
      state_q     <= ST_IDLE;
      check_cnt_q <= '0;
      err_cnt_q   <= '0;
      err_a_q     <= '0;
      err_b_q     <= '0;
      err_sum_q   <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      pipe_q      <= pipe_d;
      state_q     <= state_d;
      check_cnt_q <= check_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_a_q     <= err_a_d;
      err_b_q     <= err_b_d;
      err_sum_q   <= err_sum_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign bus.check_cnt_o = check_cnt_q;
  assign bus.err_cnt_o   = err_cnt_q;
  assign bus.status_o    = state_q;
  assign bus.err_a_o     = err_a_q;
  assign bus.err_b_o     = err_b_q;
  assign bus.err_sum_o   = err_sum_q;
  assign bus.mismatch_o  = mismatch_q;

endmodule

// File: tb/tb_adder_checker.sv
// Bench for adder_checker: a model adder answers each stimulus LAT cycles
// later (optionally corrupted), and a transaction-level model predicts the
// checker's counters, status and capture.
module tb_adder_checker;

  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 2;

  logic clk;
  logic reset_n;

  adder_checker_if #(.W(W), .CW(16)) bus  ();
  adder_checker_if #(.W(W), .CW(4))  bus4 ();

  adder_checker #(.W(W), .LAT(LAT), .CW(16)) dut (
    .clk       (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  adder_checker #(.W(W), .LAT(LAT), .CW(4)) dut4 (
    .clk       (clk),
    .reset_n_i (reset_n),
    .bus       (bus4)
  );

  assign bus4.valid_i  = bus.valid_i;
  assign bus4.a_i      = bus.a_i;
  assign bus4.b_i      = bus.b_i;
  assign bus4.sum_i    = bus.sum_i;
  assign bus4.is_odd_i = bus.is_odd_i;
  assign bus4.clear_i  = bus.clear_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scheduled model-adder responses, indexed by cycle
  logic [7:0] rs [64];
  logic       ro [64];
  bit         rv [64];

  typedef struct {
    int         due;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] act_sum;
    logic       act_odd;
  } pend_t;
  pend_t pending[$];

  // Reference model state
  int         m_chk, m_err, m_st, m_mis_cnt, obs_mis;
  logic [7:0] m_ea, m_eb, m_es;
  bit         m_mis;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_chk = 0; m_err = 0; m_st = 0; m_mis = 0;
    m_ea = 0; m_eb = 0; m_es = 0;
    pending.delete();
  endtask

  // One clock: apply stimulus/response, advance, update the model
  task automatic tick(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input int bad, input bit clr);
    logic [7:0] e, s;
    logic       o;
    int         slot;
    pend_t      p;
    bus.valid_i = v;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.clear_i = clr;
    slot = cyc % 64;
    if (rv[slot]) begin
      bus.sum_i = rs[slot]; bus.is_odd_i = ro[slot]; rv[slot] = 1'b0;
    end else begin
      bus.sum_i = 8'($urandom); bus.is_odd_i = 1'($urandom);
    end
    e = a + b;
    s = (bad == 1) ? e + 8'd1 : e;
    o = (bad == 2) ? ~e[0] : s[0];
    if (v) begin
      slot = (cyc + LAT) % 64;
      rs[slot] = s; ro[slot] = o; rv[slot] = 1'b1;
    end
    @(posedge clk); #1;
    cyc++;
    if (bus.mismatch_o === 1'b1) obs_mis++;
    m_mis = 0;
    if (clr) begin
      model_reset();
    end else begin
      while (pending.size() > 0 && pending[0].due == cyc) begin
        p = pending.pop_front();
        m_chk++;
        if (p.act_sum != 8'(p.a + p.b) || p.act_odd != e_odd(p.a, p.b)) begin
          m_err++; m_mis = 1; m_mis_cnt++;
          if (m_st != 2) begin m_ea = p.a; m_eb = p.b; m_es = p.act_sum; end
          m_st = 2;
        end else if (m_st == 0) begin
          m_st = 1;
        end
      end
      if (v) pending.push_back('{cyc + LAT, a, b, s, o});
    end
  endtask

  function automatic logic e_odd(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] full;
    full = {1'b0, a} + {1'b0, b};
    return full[0];
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'd0, 8'd0, 0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.valid_i = 0; bus.a_i = 0; bus.b_i = 0;
    bus.sum_i = 0; bus.is_odd_i = 0; bus.clear_i = 0;
    model_reset();
    #12;
    checks++; if (bus.check_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_check_cnt: got %0d want 0", bus.check_cnt_o); end
    checks++; if (bus.err_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt_o); end
    checks++; if (bus.status_o !== 2'd0) begin errors++; $display("FAIL reset_status: got %0d want 0", bus.status_o); end
    checks++; if (bus.mismatch_o !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %0b want 0", bus.mismatch_o); end
    checks++; if ({bus.err_a_o, bus.err_b_o, bus.err_sum_o} !== 24'd0) begin errors++; $display("FAIL reset_capture: got %h want 0", {bus.err_a_o, bus.err_b_o, bus.err_sum_o}); end
    @(posedge clk); #1; cyc++;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int m0;
    m0 = obs_mis;
    tick(1'b1, 8'd5, 8'd6, 0, 1'b0);
    idle(4);
    checks++; if (bus.check_cnt_o !== 16'd1) begin errors++; $display("FAIL basic_check_cnt: got %0d want 1", bus.check_cnt_o); end
    checks++; if (bus.err_cnt_o !== 16'd0) begin errors++; $display("FAIL basic_err_cnt: got %0d want 0", bus.err_cnt_o); end
    checks++; if (bus.status_o !== 2'd1) begin errors++; $display("FAIL basic_status: got %0d want 1", bus.status_o); end
    checks++; if (obs_mis !== m0) begin errors++; $display("FAIL basic_mismatch_pulses: got %0d want 0", obs_mis - m0); end
  endtask

  task automatic test_wrap();
    int m0;
    tick(1'b1, 8'd200, 8'd100, 0, 1'b0);
    idle(4);
    checks++; if (bus.status_o !== 2'd1 || bus.err_cnt_o !== 16'd0) begin errors++; $display("FAIL wrap_pass: status %0d err %0d want 1/0", bus.status_o, bus.err_cnt_o); end
    m0 = obs_mis;
    tick(1'b1, 8'd200, 8'd100, 1, 1'b0);
    idle(4);
    checks++; if (bus.err_cnt_o !== 16'd1) begin errors++; $display("FAIL wrap_err_cnt: got %0d want 1", bus.err_cnt_o); end
    checks++; if (bus.status_o !== 2'd2) begin errors++; $display("FAIL wrap_status: got %0d want 2", bus.status_o); end
    checks++; if (bus.err_a_o !== 8'd200 || bus.err_b_o !== 8'd100 || bus.err_sum_o !== 8'd45) begin errors++; $display("FAIL wrap_capture: got %0d/%0d/%0d want 200/100/45", bus.err_a_o, bus.err_b_o, bus.err_sum_o); end
    checks++; if (obs_mis - m0 !== 1) begin errors++; $display("FAIL wrap_mismatch_pulse: got %0d cycles want 1", obs_mis - m0); end
  endtask

  task automatic test_sticky();
    tick(1'b1, 8'd1, 8'd8, 0, 1'b0);
    idle(4);
    checks++; if (bus.status_o !== 2'd2 || bus.check_cnt_o !== 16'd4) begin errors++; $display("FAIL sticky_status: status %0d chk %0d want 2/4", bus.status_o, bus.check_cnt_o); end
    tick(1'b1, 8'd3, 8'd3, 1, 1'b0);
    idle(4);
    checks++; if (bus.err_cnt_o !== 16'd2) begin errors++; $display("FAIL sticky_err_cnt: got %0d want 2", bus.err_cnt_o); end
    checks++; if (bus.err_a_o !== 8'd200 || bus.err_b_o !== 8'd100 || bus.err_sum_o !== 8'd45) begin errors++; $display("FAIL sticky_capture: got %0d/%0d/%0d want 200/100/45", bus.err_a_o, bus.err_b_o, bus.err_sum_o); end
  endtask

  task automatic test_bubbles();
    int exp_cnt [8];
    exp_cnt = '{0, 0, 1, 1, 2, 3, 3, 3};
    tick(1'b0, 8'd0, 8'd0, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       tick(1'b1, 8'd0, 8'd0, 0, 1'b0);
        1:       tick(1'b0, 8'd0, 8'd0, 0, 1'b0);
        2:       tick(1'b1, 8'd1, 8'd1, 0, 1'b0);
        3:       tick(1'b1, 8'd2, 8'd2, 0, 1'b0);
        default: tick(1'b0, 8'd0, 8'd0, 0, 1'b0);
      endcase
      // Index i is the cycle relative to the first sample edge
      checks++; if (int'(bus.check_cnt_o) !== exp_cnt[i]) begin errors++; $display("FAIL bubbles_cnt_cycle%0d: got %0d want %0d", i, bus.check_cnt_o, exp_cnt[i]); end
    end
    checks++; if (bus.status_o !== 2'd1 || bus.err_cnt_o !== 16'd0) begin errors++; $display("FAIL bubbles_status: status %0d err %0d want 1/0", bus.status_o, bus.err_cnt_o); end
  endtask

  task automatic test_clear();
    tick(1'b1, 8'd4, 8'd4, 1, 1'b0);
    idle(4);
    tick(1'b1, 8'd2, 8'd2, 1, 1'b0);
    tick(1'b1, 8'd9, 8'd9, 1, 1'b1);
    idle(5);
    checks++; if (bus.check_cnt_o !== 16'd0 || bus.err_cnt_o !== 16'd0) begin errors++; $display("FAIL clear_counts: chk %0d err %0d want 0/0", bus.check_cnt_o, bus.err_cnt_o); end
    checks++; if (bus.status_o !== 2'd0) begin errors++; $display("FAIL clear_status: got %0d want 0", bus.status_o); end
    checks++; if ({bus.err_a_o, bus.err_b_o, bus.err_sum_o} !== 24'd0) begin errors++; $display("FAIL clear_capture: got %h want 0", {bus.err_a_o, bus.err_b_o, bus.err_sum_o}); end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 8'd4, 8'd4, 1, 1'b0);
    idle(4);
    checks++; if (bus.err_cnt_o !== 16'd1 || bus.status_o !== 2'd2) begin errors++; $display("FAIL rstmid_pre: err %0d status %0d want 1/2", bus.err_cnt_o, bus.status_o); end
    tick(1'b1, 8'd2, 8'd2, 1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.check_cnt_o !== 16'd0 || bus.err_cnt_o !== 16'd0 || bus.status_o !== 2'd0) begin errors++; $display("FAIL rstmid_async: chk %0d err %0d status %0d want 0/0/0", bus.check_cnt_o, bus.err_cnt_o, bus.status_o); end
    checks++; if ({bus.err_a_o, bus.err_b_o, bus.err_sum_o, bus.mismatch_o} !== 25'd0) begin errors++; $display("FAIL rstmid_capture: got %h want 0", {bus.err_a_o, bus.err_b_o, bus.err_sum_o}); end
    model_reset();
    @(posedge clk); #1; cyc++;
    reset_n = 1'b1;
    idle(5);
    checks++; if (bus.check_cnt_o !== 16'd0 || bus.err_cnt_o !== 16'd0 || bus.status_o !== 2'd0) begin errors++; $display("FAIL rstmid_flushed: chk %0d err %0d status %0d want 0/0/0", bus.check_cnt_o, bus.err_cnt_o, bus.status_o); end
  endtask

  task automatic test_saturation();
    tick(1'b0, 8'd0, 8'd0, 0, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b1, 8'(i), 8'(i), 1, 1'b0);
    idle(4);
    checks++; if (bus4.err_cnt_o !== 4'd15 || bus4.check_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_cw4: chk %0d err %0d want 15/15", bus4.check_cnt_o, bus4.err_cnt_o); end
    checks++; if (bus.err_cnt_o !== 16'd20 || bus.check_cnt_o !== 16'd20) begin errors++; $display("FAIL sat_cw16: chk %0d err %0d want 20/20", bus.check_cnt_o, bus.err_cnt_o); end
    for (int i = 0; i < 3; i++) tick(1'b1, 8'd7, 8'd1, 0, 1'b0);
    idle(4);
    checks++; if (bus4.err_cnt_o !== 4'd15 || bus4.check_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_hold: chk %0d err %0d want 15/15", bus4.check_cnt_o, bus4.err_cnt_o); end
  endtask

  task automatic test_random();
    bit v, clr;
    int bad, r;
    tick(1'b0, 8'd0, 8'd0, 0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 39) == 0);
      r   = $urandom_range(0, 7);
      bad = (r == 6) ? 1 : (r == 7) ? 2 : 0;
      tick(v, 8'($urandom), 8'($urandom), bad, clr);
      checks++; if (int'(bus.check_cnt_o) !== sat(m_chk, 65535) || int'(bus.err_cnt_o) !== sat(m_err, 65535)) begin errors++; $display("FAIL rand_counts@%0d: chk %0d err %0d want %0d/%0d", i, bus.check_cnt_o, bus.err_cnt_o, m_chk, m_err); end
      checks++; if (int'(bus4.check_cnt_o) !== sat(m_chk, 15) || int'(bus4.err_cnt_o) !== sat(m_err, 15)) begin errors++; $display("FAIL rand_counts4@%0d: chk %0d err %0d want %0d/%0d", i, bus4.check_cnt_o, bus4.err_cnt_o, sat(m_chk, 15), sat(m_err, 15)); end
      checks++; if (int'(bus.status_o) !== m_st) begin errors++; $display("FAIL rand_status@%0d: got %0d want %0d", i, bus.status_o, m_st); end
      checks++; if (bus.err_a_o !== m_ea || bus.err_b_o !== m_eb || bus.err_sum_o !== m_es) begin errors++; $display("FAIL rand_capture@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, bus.err_a_o, bus.err_b_o, bus.err_sum_o, m_ea, m_eb, m_es); end
      checks++; if (bus.mismatch_o !== m_mis) begin errors++; $display("FAIL rand_mismatch@%0d: got %0b want %0b", i, bus.mismatch_o, m_mis); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rv[i] = 1'b0;
    m_mis_cnt = 0;
    obs_mis   = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_sticky();
    test_bubbles();
    test_clear();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/adder_checker.md
Name: adder_checker

Overview:
- Synthesizable response checker at the consuming end of the adder datapath: samples each stimulus pair (a, b) when it is applied, computes the expected sum and odd flag, and delays them to line up with the adder's registered outputs.
- Compares each expected value with the adder's actual sum_o / is_odd_o, counts checks and mismatches, captures the first failing transaction, and reports IDLE/PASS/FAIL status.
- Sits beside the adder in lab test harnesses and on FPGA, where it replaces waveform inspection.

Parameters:
W, 8, operand and sum width in bits
LAT, 2, adder latency in cycles from stimulus sampled to result valid; legal range 1..8
CW, 16, width of the check and error counters

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n_i  input  1  asynchronous active-low reset; deassertion is synchronous to clk
valid_i  input  1  a_i/b_i carry a stimulus this cycle
a_i  input  W  stimulus operand a (same wires that drive the adder)
b_i  input  W  stimulus operand b
sum_i  input  W  adder sum_o
is_odd_i  input  1  adder is_odd_o
clear_i  input  1  synchronous clear of counters, status, capture and in-flight checks
check_cnt_o  output  CW  number of compares performed, saturating
err_cnt_o  output  CW  number of mismatching compares, saturating
status_o  output  2  0=IDLE, 1=PASS, 2=FAIL; 3 is never driven
err_a_o  output  W  a of the first failing transaction
err_b_o  output  W  b of the first failing transaction
err_sum_o  output  W  actual sum observed at the first failure
mismatch_o  output  1  one-cycle pulse on the cycle a compare fails

Behaviour:
- Reset (reset_n_i low): all outputs and all delay-line valid bits are 0, and status_o=IDLE. Takes effect immediately, regardless of clock, including mid-operation. In-flight checks are discarded and never compared.
- Expected values:
  - exp_sum = (a_i + b_i) mod 2^W; the carry-out is dropped.
  - exp_odd = exp_sum[0].
  - Computed in the cycle valid_i is sampled.
- Delay line: LAT stages shift every cycle, with no stall. Each stage holds {valid, a, b, exp_sum, exp_odd}.
- Compare: when the stage-LAT valid bit is 1, compare sum_i against exp_sum and is_odd_i against exp_odd.
  - A mismatch in either field counts as one error.
  - Compare occurs LAT cycles after the valid_i sample edge.
- Counters:
  - check_cnt_o increments on every compare.
  - err_cnt_o increments on every failing compare.
  - Both saturate at 2^CW-1 and hold there; they never wrap.
- Outputs are registered; counters, status and capture update on the edge at which the compare is evaluated.
- mismatch_o is high for exactly the cycle after a failing compare edge (registered).
- First-error capture: err_a_o, err_b_o and err_sum_o load only on the first failure after reset or clear. Later failures do not overwrite them.
- State machine (status_o):
  - IDLE -> PASS on the first passing compare.
  - IDLE or PASS -> FAIL on any failing compare.
  - FAIL is sticky until reset or clear_i.
  - PASS stays PASS while compares pass.
- clear_i:
  - Zeroes counters and capture, sets status IDLE, and flushes all delay-line valid bits.
  - A compare scheduled on the same edge is discarded.
  - A valid_i sampled on the same edge is also discarded; clear wins over all simultaneous events.
- valid_i low cycles insert bubbles; the bubbles are carried through the line and no compare occurs for them.
- Back-to-back valid_i every cycle is supported at full throughput.

Test Plan:
- W=8, LAT=2. Reset, then valid_i with a=5, b=6, and a model adder returning sum 11, odd 1 two cycles later -> check_cnt=1, err_cnt=0, status PASS, mismatch_o never high.
- Wrap-around: a=200, b=100; model returns 44, odd 0 -> pass. Then inject sum 45, odd 1 -> err_cnt=1, status FAIL, err_a=200, err_b=100, err_sum=45, mismatch_o pulses for one cycle.
- Sticky FAIL and first capture:
  - After the failure above, send a=1, b=8 with a correct response -> status stays FAIL, capture unchanged.
  - Then send a=3, b=3 with a wrong sum of 7 -> err_cnt=2, capture still holds 200/100/45.
- Bubbles and throughput:
  - Stimulus pattern valid 1,0,1,1 with pairs (0,0), (1,1), (2,2) and correct responses -> check_cnt=3.
  - Compares land exactly on cycles 2, 4 and 5 after the first sample.
- Clear and reset mid-flight:
  - Assert clear_i one cycle after a valid sample (a=2, b=2) -> that check is never counted; counters 0, status IDLE.
  - Repeat, dropping reset_n_i between clock edges -> outputs go to 0 immediately.
- Saturation (CW=4): 20 failing compares -> err_cnt=15, check_cnt=15, both held.
